matrix_conv_engine: RTL and testbench

Parametrised successor to the single-mode memory-mapped convolution FSM. It reads a 6-word header and the filter from shared RAM, and caches the filter in a local buffer so it is fetched only once. It then computes a strided 2-D valid convolution with signed MAC, optional saturation and optional ReLU, and writes results back to RAM. It sits on the same single-port request/opdone memory interface as the other accelerator blocks.

---
 rtl/conv_pkg.sv | 34 +++
 rtl/matrix_conv_engine_if.sv | 23 ++
 rtl/conv_filter_buf.sv | 25 ++
 rtl/matrix_conv_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_matrix_conv_engine.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared encodings for the memory-mapped convolution engine.
package conv_pkg;

  typedef logic [1:0] mem_op_t;

  localparam mem_op_t MEM_NONE = 2'b00;
  localparam mem_op_t MEM_RD   = 2'b01;
  localparam mem_op_t MEM_WR   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CHECK,
    ST_LOAD_F,
    ST_ACC_RD,
    ST_MAC,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Header word offsets relative to BASE_ADDR
  localparam int unsigned HDR_WA    = 0;
  localparam int unsigned HDR_HA    = 1;
  localparam int unsigned HDR_WF    = 2;
  localparam int unsigned HDR_HF    = 3;
  localparam int unsigned HDR_S     = 4;
  localparam int unsigned HDR_MODE  = 5;
  localparam int unsigned HDR_WORDS = 6;

  // MODE word bit indices
  localparam int unsigned MODE_RELU = 0;
  localparam int unsigned MODE_SAT  = 1;

endpackage

// File: rtl/matrix_conv_engine_if.sv
// Single-port request/opdone memory bus shared by the accelerator blocks.
interface matrix_conv_engine_if
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              mem_opdone;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;
  logic [ADDR_W-1:0] addr_o;
  mem_op_t           mem_operation;

  modport master (
    input  mem_opdone, data_i,
    output data_o, addr_o, mem_operation
  );

  modport slave (
    output mem_opdone, data_i,
    input  data_o, addr_o, mem_operation
  );
endinterface

// File: rtl/conv_filter_buf.sv
// Local filter cache: synchronous write, combinational read.
module conv_filter_buf #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 64,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Store one filter word per completed LOAD_F read
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Coefficient lookup for the current MAC step
  always_comb begin
    rdata = mem_q[raddr];
  end
endmodule

// File: rtl/matrix_conv_engine.sv
// Strided 2-D valid convolution over shared RAM with a cached filter,
// signed MAC, optional saturation and optional ReLU.
module matrix_conv_engine
  import conv_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       ACC_W      = 64,
  parameter int unsigned       FILT_DEPTH = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  matrix_conv_engine_if.master        mem,
  output logic                        done,
  output logic                        error
);
  localparam int unsigned       BUF_AW = $clog2(FILT_DEPTH);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  state_t            state_q, state_d;
  mem_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d, error_q, error_d;
  logic [2:0]        hdr_idx_q, hdr_idx_d;
  logic [ADDR_W-1:0] wa_q, wa_d, ha_q, ha_d, wf_q, wf_d, hf_q, hf_d, s_q, s_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] f_idx_q, f_idx_d, k_q, k_d, l_q, l_d;
  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d, r_idx_q, r_idx_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [ACC_W-1:0]  acc_q, acc_d;

  logic [ADDR_W-1:0] nfilt, a_base, f_base, r_base, a_addr, hdr_word;
  logic [ADDR_W:0]   col_next, row_next;
  logic              col_more, row_more, hdr_bad, buf_we, req_done;
  logic [DATA_W-1:0] filt_w;
  logic [ACC_W-1:0]  a_ext, f_ext, prod;

  conv_filter_buf #(.DATA_W(DATA_W), .DEPTH(FILT_DEPTH)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (f_idx_q[BUF_AW-1:0]),
    .wdata (mem.data_i),
    .raddr (f_idx_q[BUF_AW-1:0]),
    .rdata (filt_w)
  );

  function automatic logic [DATA_W-1:0] post(input logic [ACC_W-1:0] acc,
                                             input logic [1:0]       mode);
    logic [ACC_W-1:0]  smax, smin;
    logic [DATA_W-1:0] r;
    smax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    smin = ~smax;
    r    = acc[DATA_W-1:0];
    if (mode[MODE_SAT]) begin
      if ($signed(acc) > $signed(smax))      r = smax[DATA_W-1:0];
      else if ($signed(acc) < $signed(smin)) r = smin[DATA_W-1:0];
    end
    if (mode[MODE_RELU] && r[DATA_W-1]) r = '0;
    return r;
  endfunction

  // Derived addresses, loop-bound tests and MAC operands
  always_comb begin
    nfilt    = wf_q * hf_q;
    a_base   = BASE_ADDR + ADDR_W'(HDR_WORDS);
    f_base   = a_base + wa_q * ha_q;
    r_base   = f_base + nfilt;
    a_addr   = a_base + (row_q + k_q) * wa_q + col_q + l_q;
    hdr_word = ADDR_W'(mem.data_i);
    // Window positions are tracked as element offsets rather than output
    // indices, so no divide is needed to find OW/OH; the extra bit keeps
    // a large stride from wrapping past the last legal position.
    col_next = {1'b0, col_q} + {1'b0, s_q};
    row_next = {1'b0, row_q} + {1'b0, s_q};
    col_more = col_next <= {1'b0, wa_q - wf_q};
    row_more = row_next <= {1'b0, ha_q - hf_q};
    hdr_bad  = (s_q == '0) || (wf_q == '0) || (hf_q == '0) || (wf_q > wa_q) ||
               (hf_q > ha_q) || (nfilt > ADDR_W'(FILT_DEPTH));
    req_done = (op_q != MEM_NONE) && mem.mem_opdone;
    buf_we   = (state_q == ST_LOAD_F) && req_done;
    a_ext    = {{(ACC_W-DATA_W){a_q[DATA_W-1]}}, a_q};
    f_ext    = {{(ACC_W-DATA_W){filt_w[DATA_W-1]}}, filt_w};
    prod     = a_ext * f_ext;
  end

  // Sequencer next-state: every request state issues when the bus is idle
  // and drops back to MEM_NONE on opdone, which guarantees the idle gap.
  always_comb begin
    state_d = state_q;  op_d = op_q;  addr_d = addr_q;  wdata_d = wdata_q;
    done_d  = done_q;   error_d = error_q;  hdr_idx_d = hdr_idx_q;
    wa_d = wa_q;  ha_d = ha_q;  wf_d = wf_q;  hf_d = hf_q;  s_d = s_q;
    mode_d = mode_q;  f_idx_d = f_idx_q;  k_d = k_q;  l_d = l_q;
    row_d = row_q;  col_d = col_q;  r_idx_d = r_idx_q;  a_d = a_q;  acc_d = acc_q;
    case (state_q)
      ST_IDLE: begin
        done_d  = 1'b0;
        error_d = 1'b0;
        if (enable) begin
          state_d   = ST_HDR;
          hdr_idx_d = '0;
        end
      end
      ST_HDR: begin
        if (op_q == MEM_NONE) begin
          op_d   = MEM_RD;
          addr_d = BASE_ADDR + ADDR_W'(hdr_idx_q);
        end else if (req_done) begin
          op_d = MEM_NONE;
          case (hdr_idx_q)
            3'(HDR_WA):   wa_d   = hdr_word;
            3'(HDR_HA):   ha_d   = hdr_word;
            3'(HDR_WF):   wf_d   = hdr_word;
            3'(HDR_HF):   hf_d   = hdr_word;
            3'(HDR_S):    s_d    = hdr_word;
            3'(HDR_MODE): mode_d = mem.data_i[1:0];
            default: ;
          endcase
          if (hdr_idx_q == 3'(HDR_MODE)) state_d = ST_CHECK;
          else hdr_idx_d = hdr_idx_q + 3'd1;
        end
      end
      ST_CHECK: begin
        if (hdr_bad) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          state_d = ST_LOAD_F;
          f_idx_d = '0;
        end
      end
      ST_LOAD_F: begin
        if (op_q == MEM_NONE) begin
          op_d   = MEM_RD;
          addr_d = f_base + f_idx_q;
        end else if (req_done) begin
          op_d = MEM_NONE;
          if (f_idx_q == nfilt - ONE) begin
            state_d = ST_ACC_RD;
            f_idx_d = '0;  k_d = '0;  l_d = '0;
            row_d = '0;  col_d = '0;  r_idx_d = '0;  acc_d = '0;
          end else begin
            f_idx_d = f_idx_q + ONE;
          end
        end
      end
      ST_ACC_RD: begin
        if (op_q == MEM_NONE) begin
          op_d   = MEM_RD;
          addr_d = a_addr;
        end else if (req_done) begin
          op_d    = MEM_NONE;
          a_d     = mem.data_i;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        // f_idx walks k*WF+l in lock-step with the window scan
        acc_d   = acc_q + prod;
        f_idx_d = f_idx_q + ONE;
        state_d = ST_ACC_RD;
        if (l_q == wf_q - ONE) begin
          l_d = '0;
          if (k_q == hf_q - ONE) begin
            k_d     = '0;
            f_idx_d = '0;
            state_d = ST_WRITE;
          end else begin
            k_d = k_q + ONE;
          end
        end else begin
          l_d = l_q + ONE;
        end
      end
      ST_WRITE: begin
        if (op_q == MEM_NONE) begin
          op_d    = MEM_WR;
          addr_d  = r_base + r_idx_q;
          wdata_d = post(acc_q, mode_q);
        end else if (req_done) begin
          op_d    = MEM_NONE;
          acc_d   = '0;
          r_idx_d = r_idx_q + ONE;
          state_d = ST_ACC_RD;
          if (col_more) begin
            col_d = col_next[ADDR_W-1:0];
          end else begin
            col_d = '0;
            if (row_more) begin
              row_d = row_next[ADDR_W-1:0];
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
        if (!enable) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any job in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;  op_q <= MEM_NONE;  addr_q <= '0;  wdata_q <= '0;
      done_q  <= 1'b0;     error_q <= 1'b0;   hdr_idx_q <= '0;
      wa_q <= '0;  ha_q <= '0;  wf_q <= '0;  hf_q <= '0;  s_q <= '0;  mode_q <= '0;
      f_idx_q <= '0;  k_q <= '0;  l_q <= '0;  row_q <= '0;  col_q <= '0;
      r_idx_q <= '0;  a_q <= '0;  acc_q <= '0;
    end else begin
      state_q <= state_d;  op_q <= op_d;  addr_q <= addr_d;  wdata_q <= wdata_d;
      done_q  <= done_d;   error_q <= error_d;  hdr_idx_q <= hdr_idx_d;
      wa_q <= wa_d;  ha_q <= ha_d;  wf_q <= wf_d;  hf_q <= hf_d;  s_q <= s_d;  mode_q <= mode_d;
      f_idx_q <= f_idx_d;  k_q <= k_d;  l_q <= l_d;  row_q <= row_d;  col_q <= col_d;
      r_idx_q <= r_idx_d;  a_q <= a_d;  acc_q <= acc_d;
    end
  end

  assign mem.mem_operation = op_q;
  assign mem.addr_o        = addr_q;
  assign mem.data_o        = wdata_q;
  assign done              = done_q;
  assign error             = error_q;

endmodule

// File: tb/tb_matrix_conv_engine.sv
// Directed bench for matrix_conv_engine with a randomly-delayed memory model.
module tb_matrix_conv_engine;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic done, error;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  logic [31:0] wlog_addr [256];
  logic [31:0] wlog_data [256];
  int unsigned rd_cnt = 0, wr_cnt = 0, proto_viol = 0;

  matrix_conv_engine_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  matrix_conv_engine #(
    .DATA_W(32), .ADDR_W(32), .ACC_W(64), .FILT_DEPTH(64), .BASE_ADDR(32'd0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mem(bus), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Memory responder: 0-5 cycle latency, stability/idle-gap monitor,
  // spurious opdone pulses while the bus is idle.
  bit          pending = 1'b0, just_done = 1'b0;
  logic [1:0]  p_op;
  logic [31:0] p_addr, p_data;
  int unsigned lat_left;
  always @(negedge clk) begin
    if (reset) begin
      pending = 1'b0; just_done = 1'b0; bus.mem_opdone = 1'b0; bus.data_i = '0;
    end else begin
      bus.mem_opdone = 1'b0;
      if (just_done) begin
        just_done = 1'b0;
        if (bus.mem_operation !== 2'b00) proto_viol++;
        if ($urandom_range(0, 3) == 0) begin bus.mem_opdone = 1'b1; bus.data_i = $urandom; end
      end else if (bus.mem_operation !== 2'b00) begin
        if (!pending) begin
          pending = 1'b1; p_op = bus.mem_operation; p_addr = bus.addr_o; p_data = bus.data_o;
          lat_left = $urandom_range(0, 5);
        end else if (bus.mem_operation !== p_op || bus.addr_o !== p_addr || bus.data_o !== p_data) begin
          proto_viol++;
        end
        if (lat_left == 0) begin
          pending = 1'b0; just_done = 1'b1; bus.mem_opdone = 1'b1;
          if (p_op == 2'b01) begin
            bus.data_i = mem[p_addr[7:0]]; rd_cnt++;
          end else if (p_op == 2'b11) begin
            wlog_addr[wr_cnt % 256] = p_addr; wlog_data[wr_cnt % 256] = p_data; wr_cnt++;
          end else proto_viol++;
        end else lat_left--;
      end else if (pending) begin
        proto_viol++;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.mem_opdone = 1'b1; bus.data_i = $urandom;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEADBEEF;
  endtask

  task automatic set_hdr(input int unsigned wa, ha, wf, hf, s, mode);
    mem[0] = 32'(wa); mem[1] = 32'(ha); mem[2] = 32'(wf);
    mem[3] = 32'(hf); mem[4] = 32'(s);  mem[5] = 32'(mode);
  endtask

  task automatic run_job(input int unsigned budget, output bit timeout);
    timeout = 1'b1;
    enable  = 1'b1;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic finish_job();
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.mem_operation, bus.addr_o, bus.data_o, done, error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: op=%b addr=%0h data=%0h done=%b error=%b, required all 0",
               bus.mem_operation, bus.addr_o, bus.data_o, done, error);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // 3x3 A=1..9, identity-diagonal 2x2 filter, stride 1
  task automatic test_basic();
    logic [31:0] exp [4] = '{32'd6, 32'd8, 32'd12, 32'd14};
    int unsigned r0, w0, pv0;
    bit to;
    clear_mem(); set_hdr(3, 3, 2, 2, 1, 0);
    for (int i = 0; i < 9; i++) mem[6+i] = 32'(i + 1);
    mem[15] = 32'd1; mem[16] = 32'd0; mem[17] = 32'd0; mem[18] = 32'd1;
    r0 = rd_cnt; w0 = wr_cnt; pv0 = proto_viol;
    run_job(3000, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: done never rose"); end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL basic_flags: done=%b error=%b, required 1/0", done, error); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wlog_addr[(w0+i)%256] !== 32'(19 + i) || wlog_data[(w0+i)%256] !== exp[i]) begin
        errors++;
        $display("FAIL basic_r%0d: got @%0d=%0d, required @%0d=%0d", i,
                 wlog_addr[(w0+i)%256], wlog_data[(w0+i)%256], 19 + i, exp[i]);
      end
    end
    checks++; if (rd_cnt - r0 !== 26) begin errors++; $display("FAIL basic_reads: got %0d required 26", rd_cnt - r0); end
    checks++; if (wr_cnt - w0 !== 4) begin errors++; $display("FAIL basic_writes: got %0d required 4", wr_cnt - w0); end
    checks++; if (proto_viol !== pv0) begin errors++; $display("FAIL basic_protocol: %0d violations, required 0", proto_viol - pv0); end
    finish_job();
    checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL basic_release: done=%b error=%b, required 0/0", done, error); end
  endtask

  // 4x4 A=0..15, 2x2 ones, stride 2
  task automatic test_stride();
    logic [31:0] exp [4] = '{32'd10, 32'd18, 32'd42, 32'd50};
    int unsigned r0, w0;
    bit to;
    clear_mem(); set_hdr(4, 4, 2, 2, 2, 0);
    for (int i = 0; i < 16; i++) mem[6+i] = 32'(i);
    for (int i = 0; i < 4; i++) mem[22+i] = 32'd1;
    r0 = rd_cnt; w0 = wr_cnt;
    run_job(3000, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL stride_timeout: done never rose"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wlog_addr[(w0+i)%256] !== 32'(26 + i) || wlog_data[(w0+i)%256] !== exp[i]) begin
        errors++;
        $display("FAIL stride_r%0d: got @%0d=%0d, required @%0d=%0d", i,
                 wlog_addr[(w0+i)%256], wlog_data[(w0+i)%256], 26 + i, exp[i]);
      end
    end
    checks++; if (rd_cnt - r0 !== 26 || wr_cnt - w0 !== 4) begin errors++; $display("FAIL stride_counts: reads=%0d writes=%0d, required 26/4", rd_cnt - r0, wr_cnt - w0); end
    finish_job();
  endtask

  // 1x1 filter -1 over A=[3,-2]; MODE 0 then ReLU
  task automatic test_signed_relu();
    logic [31:0] exp [2][2] = '{'{32'hFFFFFFFD, 32'd2}, '{32'd0, 32'd2}};
    int unsigned w0;
    bit to;
    for (int m = 0; m < 2; m++) begin
      clear_mem(); set_hdr(2, 1, 1, 1, 1, m);
      mem[6] = 32'd3; mem[7] = 32'hFFFFFFFE; mem[8] = 32'hFFFFFFFF;
      w0 = wr_cnt;
      run_job(1000, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL relu_timeout mode=%0d", m); end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wlog_addr[(w0+i)%256] !== 32'(9 + i) || wlog_data[(w0+i)%256] !== exp[m][i]) begin
          errors++;
          $display("FAIL relu_m%0d_r%0d: got @%0d=%0h, required @%0d=%0h", m, i,
                   wlog_addr[(w0+i)%256], wlog_data[(w0+i)%256], 9 + i, exp[m][i]);
        end
      end
      finish_job();
    end
  endtask

  // 0x7FFFFFFF * 2 with saturation, then wrapped
  task automatic test_saturate();
    int unsigned modes [2] = '{2, 0};
    logic [31:0] exp [2] = '{32'h7FFFFFFF, 32'hFFFFFFFE};
    int unsigned w0;
    bit to;
    for (int m = 0; m < 2; m++) begin
      clear_mem(); set_hdr(1, 1, 1, 1, 1, modes[m]);
      mem[6] = 32'h7FFFFFFF; mem[7] = 32'd2;
      w0 = wr_cnt;
      run_job(1000, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL sat_timeout mode=%0d", modes[m]); end
      checks++;
      if (wr_cnt - w0 !== 1 || wlog_addr[w0%256] !== 32'd8 || wlog_data[w0%256] !== exp[m]) begin
        errors++;
        $display("FAIL sat_mode%0d: got %0d writes @%0d=%0h, required 1 @8=%0h", modes[m],
                 wr_cnt - w0, wlog_addr[w0%256], wlog_data[w0%256], exp[m]);
      end
      finish_job();
    end
  endtask

  // Filter exactly FILT_DEPTH long is accepted
  task automatic test_filt_depth_max();
    int unsigned r0, w0;
    bit to;
    clear_mem(); set_hdr(64, 1, 64, 1, 1, 0);
    for (int i = 6; i < 134; i++) mem[i] = 32'd1;
    r0 = rd_cnt; w0 = wr_cnt;
    run_job(5000, to);
    checks++; if (to !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL depth64_flags: timeout=%b error=%b, required 0/0", to, error); end
    checks++;
    if (rd_cnt - r0 !== 134 || wr_cnt - w0 !== 1 || wlog_addr[w0%256] !== 32'd134 || wlog_data[w0%256] !== 32'd64) begin
      errors++;
      $display("FAIL depth64_result: reads=%0d writes=%0d @%0d=%0d, required 134/1 @134=64",
               rd_cnt - r0, wr_cnt - w0, wlog_addr[w0%256], wlog_data[w0%256]);
    end
    finish_job();
  endtask

  // Invalid headers: WF>WA, S=0, WF*HF=65
  task automatic test_errors();
    int unsigned hdr [3][5] = '{'{3, 3, 4, 1, 1}, '{3, 3, 2, 2, 0}, '{65, 1, 65, 1, 1}};
    int unsigned r0, w0;
    bit to;
    for (int c = 0; c < 3; c++) begin
      clear_mem(); set_hdr(hdr[c][0], hdr[c][1], hdr[c][2], hdr[c][3], hdr[c][4], 0);
      r0 = rd_cnt; w0 = wr_cnt;
      run_job(500, to);
      checks++;
      if (to !== 1'b0 || done !== 1'b1 || error !== 1'b1) begin
        errors++; $display("FAIL err%0d_flags: timeout=%b done=%b error=%b, required 0/1/1", c, to, done, error);
      end
      checks++;
      if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 6) begin
        errors++; $display("FAIL err%0d_traffic: reads=%0d writes=%0d, required 6/0", c, rd_cnt - r0, wr_cnt - w0);
      end
      finish_job();
      checks++;
      if (done !== 1'b0 || error !== 1'b0) begin
        errors++; $display("FAIL err%0d_release: done=%b error=%b, required 0/0", c, done, error);
      end
    end
  endtask

  // Reset while the filter is loading, then a clean re-run
  task automatic test_reset_mid_load();
    bit found = 1'b0;
    int unsigned busy = 0;
    clear_mem(); set_hdr(3, 3, 2, 2, 1, 0);
    for (int i = 0; i < 9; i++) mem[6+i] = 32'(i + 1);
    enable = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.mem_operation === 2'b01 && bus.addr_o >= 32'd15 && bus.addr_o <= 32'd18) begin
        found = 1'b1; break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL midload_reach: no filter read seen, required one"); end
    reset = 1'b1; enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_operation, bus.addr_o, bus.data_o, done, error} !== '0) begin
      errors++;
      $display("FAIL midload_reset: op=%b addr=%0h data=%0h done=%b error=%b, required all 0",
               bus.mem_operation, bus.addr_o, bus.data_o, done, error);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_operation !== 2'b00) busy++;
    end
    checks++; if (busy !== 0) begin errors++; $display("FAIL midload_quiet: %0d request cycles, required 0", busy); end
    test_basic();
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    test_reset();
    test_basic();
    test_stride();
    test_signed_relu();
    test_saturate();
    test_filt_depth_max();
    test_errors();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
